ppu_pixel_framer: RTL
=====================

Name: ppu_pixel_framer

Overview:
- Sits directly upstream of the testbench frame recorder.
- Takes the raw PPU dot stream (pixel, valid, vblank level) and produces a clean stream for the recorder: exactly IMAGE_W*IMAGE_H pixel_en beats per frame, bracketed by a `frame` level whose rising edge marks frame boundaries.
- Pads short frames, drops excess pixels, and reports frame count and sticky error flags.

Parameters:
- IMAGE_W, 256, pixels per line.
- IMAGE_H, 240, lines per frame.
- PAD_PIXEL, 8'h0F, palette index emitted for missing pixels (NES black).
- MIN_FRAME_HI, 4, minimum cycles `frame` stays high (recorder needs >=2 cycles between edge and first pixel).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ppu_pixel  in  8  PPU palette index (bits 5:0 significant, passed through unchanged)
- ppu_pixel_valid  in  1  one visible dot this cycle
- ppu_vblank  in  1  PPU vblank level
- pixel  out  8  registered pixel to recorder
- pixel_en  out  1  pixel valid strobe
- frame  out  1  high while in BLANK; rising edge = new frame
- frame_cnt  out  16  completed frames since reset, wraps at 16'hFFFF->0
- err_short  out  1  sticky: some frame needed padding
- err_long  out  1  sticky: a pixel was dropped (excess, or arrived in BLANK/PAD)
- checksum  out  16  see Optional Feature

Behaviour:
- Reset (async, rst=1): state=WAIT_SYNC, all outputs 0, counters 0, vblank edge register 0.
- vblank_rise/fall detected against a registered copy of ppu_vblank (1-cycle detection latency).
- Pixel counter pcnt has width clog2(IMAGE_W*IMAGE_H+1); TOTAL=IMAGE_W*IMAGE_H.
- States:
  - WAIT_SYNC: ignore all input; on vblank_rise -> BLANK. No frame_cnt increment.
  - BLANK: frame=1; pcnt=0; hold counter counts cycles in BLANK. Exit to ACTIVE when ppu_vblank=0 AND hold >= MIN_FRAME_HI. ppu_pixel_valid here -> dropped, err_long<=1.
  - ACTIVE: frame=0. On ppu_pixel_valid with pcnt<TOTAL: pixel<=ppu_pixel, pixel_en<=1 next cycle (latency 1), pcnt++. With pcnt==TOTAL: dropped, err_long<=1, pixel_en=0.
    - On vblank_rise: if pcnt (including any pixel accepted the same cycle) ==TOTAL -> BLANK, frame_cnt++. Else -> PAD, err_short<=1.
  - PAD: emit pixel=PAD_PIXEL, pixel_en=1 every cycle, pcnt++ until pcnt==TOTAL, then -> BLANK, frame_cnt++. Input pixels dropped (err_long<=1). vblank_fall during PAD is ignored; BLANK still enforces MIN_FRAME_HI.
- pixel_en is 0 in WAIT_SYNC and BLANK; pixel holds its last value when pixel_en=0.
- Transition into BLANK sets frame=1 in the same registered update as the last pixel_en beat + 1 cycle. The last pixel of a frame always precedes frame's rising edge.
- Simultaneous valid + vblank_rise in ACTIVE: pixel accepted first, then transition uses the updated count.
- Reset mid-frame: immediate return to WAIT_SYNC. Nothing emitted until the next vblank rise, so no partial frame reaches the recorder.

Optional Feature:
- Macro FRAMER_CHECKSUM_EN.
- Defined: 16-bit running sum (mod 2^16) of all emitted pixel values, pad pixels included. On entry to BLANK, the sum is latched to `checksum` and the accumulator cleared. Allows frame comparison without PPM dumps.
- Undefined: `checksum` tied to 0, no accumulator logic.

Test Plan (IMAGE_W=4, IMAGE_H=2, MIN_FRAME_HI=4):
- Normal frame: reset, vblank pulse, then 8 valid pixels 1..8, then vblank rise -> pixel_en 8 beats with values 1..8, frame rises after last beat, frame_cnt=1, errors 0, checksum=36 (with macro).
- Short frame: 5 pixels 1..5 then vblank rise -> 3 extra beats of 8'h0F, frame rises, err_short=1, frame_cnt=1, checksum=60.
- Long frame: 10 pixels -> only first 8 emitted, err_long=1, err_short=0.
- Short vblank: vblank high 1 cycle -> frame stays high >=4 cycles; pixel valid on cycle 2 of BLANK is dropped, err_long=1.
- Mid-frame start and reset: pixels before first vblank produce no pixel_en; assert rst after 3 pixels of frame 2 -> all outputs 0 immediately, frame_cnt=0, resumes only after next vblank rise.
- Same-cycle edge: 8th pixel valid in the same cycle vblank_rise is detected -> 8 beats, no padding, err_short=0.

Source files
------------

// File: rtl/ppu_pixel_framer.sv
// ppu_pixel_framer
// Conditions the raw PPU dot stream for the frame recorder: every frame is
// exactly IMAGE_W*IMAGE_H pixel_en beats, short frames padded with PAD_PIXEL,
// excess pixels dropped, and `frame` rises after the last beat of each frame.
// Optional per-frame running checksum of emitted pixels: define FRAMER_CHECKSUM_EN.

module ppu_pixel_framer #(
    parameter int unsigned IMAGE_W      = 256,
    parameter int unsigned IMAGE_H      = 240,
    parameter logic [7:0]  PAD_PIXEL    = 8'h0F,
    parameter int unsigned MIN_FRAME_HI = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ppu_pixel,
    input  logic        ppu_pixel_valid,
    input  logic        ppu_vblank,
    output logic [7:0]  pixel,
    output logic        pixel_en,
    output logic        frame,
    output logic [15:0] frame_cnt,
    output logic        err_short,
    output logic        err_long,
    output logic [15:0] checksum
);

    localparam int unsigned   TOTAL    = IMAGE_W * IMAGE_H;
    localparam int unsigned   PW       = $clog2(TOTAL + 1);
    localparam int unsigned   HW       = (MIN_FRAME_HI < 1) ? 1 : $clog2(MIN_FRAME_HI + 1);
    localparam logic [PW-1:0] TOTAL_C  = PW'(TOTAL);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_FRAME_HI);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_BLANK     = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_PAD       = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;

    logic           r_vblank_d;
    logic [PW-1:0]  r_pcnt;
    logic [HW-1:0]  r_hold;
    logic [7:0]     r_pixel;
    logic           r_pixel_en;
    logic           r_frame;
    logic [15:0]    r_frame_cnt;
    logic           r_err_short;
    logic           r_err_long;

    logic           w_vblank_rise;
    logic [PW-1:0]  w_pcnt_nx;
    logic [HW-1:0]  w_hold_nx;
    logic [7:0]     w_pixel_nx;
    logic           w_pixel_en_nx;
    logic [15:0]    w_frame_cnt_nx;
    logic           w_err_short_nx;
    logic           w_err_long_nx;
    logic           w_enter_blank;

    assign w_vblank_rise = ppu_vblank & ~r_vblank_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, pixel acceptance/padding, counters and sticky error flags
    always_comb begin
        w_state_nx     = r_state;
        w_pcnt_nx      = r_pcnt;
        w_hold_nx      = r_hold;
        w_pixel_nx     = r_pixel;
        w_pixel_en_nx  = 1'b0;
        w_frame_cnt_nx = r_frame_cnt;
        w_err_short_nx = r_err_short;
        w_err_long_nx  = r_err_long;
        w_enter_blank  = 1'b0;

        case (r_state)
            ST_WAIT_SYNC: begin
                if (w_vblank_rise) begin
                    w_state_nx    = ST_BLANK;
                    w_enter_blank = 1'b1;
                end
            end

            ST_BLANK: begin
                w_pcnt_nx = '0;
                if (ppu_pixel_valid) begin
                    w_err_long_nx = 1'b1;
                end
                if (r_hold < HOLD_MAX) begin
                    w_hold_nx = r_hold + HW'(1);
                end
                if (!ppu_vblank && (r_hold >= HOLD_MAX)) begin
                    w_state_nx = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (ppu_pixel_valid) begin
                    if (r_pcnt < TOTAL_C) begin
                        w_pixel_nx    = ppu_pixel;
                        w_pixel_en_nx = 1'b1;
                        w_pcnt_nx     = r_pcnt + PW'(1);
                    end else begin
                        w_err_long_nx = 1'b1;
                    end
                end
                // A pixel accepted in the same cycle as the vblank edge counts
                // toward completion, so compare against the updated count.
                if (w_vblank_rise) begin
                    if (w_pcnt_nx == TOTAL_C) begin
                        w_state_nx     = ST_BLANK;
                        w_frame_cnt_nx = r_frame_cnt + 16'd1;
                        w_enter_blank  = 1'b1;
                    end else begin
                        w_state_nx     = ST_PAD;
                        w_err_short_nx = 1'b1;
                    end
                end
            end

            ST_PAD: begin
                if (ppu_pixel_valid) begin
                    w_err_long_nx = 1'b1;
                end
                if (r_pcnt < TOTAL_C) begin
                    w_pixel_nx    = PAD_PIXEL;
                    w_pixel_en_nx = 1'b1;
                    w_pcnt_nx     = r_pcnt + PW'(1);
                end
                if (w_pcnt_nx == TOTAL_C) begin
                    w_state_nx     = ST_BLANK;
                    w_frame_cnt_nx = r_frame_cnt + 16'd1;
                    w_enter_blank  = 1'b1;
                end
            end

            default: begin
                w_state_nx = ST_WAIT_SYNC;
            end
        endcase

        if (w_enter_blank) begin
            w_pcnt_nx = '0;
            w_hold_nx = '0;
        end
    end

    // Datapath registers; frame trails the BLANK state by one cycle so the
    // final beat of a frame always lands before the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblank_d  <= 1'b0;
            r_pcnt      <= '0;
            r_hold      <= '0;
            r_pixel     <= '0;
            r_pixel_en  <= 1'b0;
            r_frame     <= 1'b0;
            r_frame_cnt <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_vblank_d  <= ppu_vblank;
            r_pcnt      <= w_pcnt_nx;
            r_hold      <= w_hold_nx;
            r_pixel     <= w_pixel_nx;
            r_pixel_en  <= w_pixel_en_nx;
            r_frame     <= (r_state == ST_BLANK);
            r_frame_cnt <= w_frame_cnt_nx;
            r_err_short <= w_err_short_nx;
            r_err_long  <= w_err_long_nx;
        end
    end

    assign pixel     = r_pixel;
    assign pixel_en  = r_pixel_en;
    assign frame     = r_frame;
    assign frame_cnt = r_frame_cnt;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;

`ifdef FRAMER_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_checksum;
    logic [15:0] w_acc_sum;

    assign w_acc_sum = r_acc + (w_pixel_en_nx ? {8'h00, w_pixel_nx} : 16'h0000);

    // Running sum of emitted beats, latched and cleared on entry to BLANK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_checksum <= '0;
        end else if (w_enter_blank) begin
            r_acc      <= '0;
            r_checksum <= w_acc_sum;
        end else begin
            r_acc      <= w_acc_sum;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule
